unary_adder_driver: RTL and testbench

//  Transmit/receive end for the serial unary adder. Accepts two binary operands over a

---
 rtl/unary_adder_driver_if.sv | 30 +++
 rtl/unary_adder_driver.sv | 122 ++++++++++++
 tb/tb_unary_adder_driver.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/unary_adder_driver_if.sv
// Operand handshake, unary adder stream and result bundle for unary_adder_driver.
// The slave modport is the driver block; the master modport is its surroundings.
interface unary_adder_driver_if #(
  parameter int unsigned VAL_W = 3,
  parameter int unsigned RES_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [VAL_W-1:0] a_val;
  logic [VAL_W-1:0] b_val;
  logic             A;
  logic             B;
  logic             en;
  logic             read_or_write;
  logic             dout;
  logic             C;
  logic             res_valid;
  logic [RES_W-1:0] res_sum;
  logic             res_carry;

  modport master (
    output in_valid, a_val, b_val, dout, C,
    input  in_ready, A, B, en, read_or_write, res_valid, res_sum, res_carry
  );

  modport slave (
    input  in_valid, a_val, b_val, dout, C,
    output in_ready, A, B, en, read_or_write, res_valid, res_sum, res_carry
  );
endinterface

// File: rtl/unary_adder_driver.sv
// Drives two thermometer-coded operands into the serial unary adder, then counts the
// unary dout stream back into a binary sum together with the OR of the C flag.
module unary_adder_driver #(
  parameter int unsigned FRAME_LEN = 5,
  parameter int unsigned VAL_W     = 3,
  parameter int unsigned RES_W     = 4,
  parameter int unsigned DRAIN_LEN = 12
) (
  input logic                 clk,
  input logic                 rst_n,
  unary_adder_driver_if.slave bus
);

  localparam int unsigned KW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned DW = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;

  typedef enum logic [1:0] {StIdle, StSend, StDrain, StDone} state_e;

  state_e           state_q;
  logic [KW-1:0]    k_q;
  logic [DW-1:0]    d_q;
  logic [VAL_W-1:0] a_lat_q;
  logic [VAL_W-1:0] b_lat_q;
  logic             a_q;
  logic             b_q;
  logic             en_q;
  logic             rw_q;
  logic             res_valid_q;
  logic [RES_W-1:0] res_sum_q;
  logic             res_carry_q;

  function automatic logic [VAL_W-1:0] clamp(input logic [VAL_W-1:0] v);
    return (v > VAL_W'(FRAME_LEN)) ? VAL_W'(FRAME_LEN) : v;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      k_q         <= '0;
      d_q         <= '0;
      a_lat_q     <= '0;
      b_lat_q     <= '0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      en_q        <= 1'b0;
      rw_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_carry_q <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;

      // Sample dout/C in exactly the cycles the adder is presented with write mode.
      if (rw_q) begin
        if (bus.dout && (res_sum_q != '1)) begin
          res_sum_q <= res_sum_q + RES_W'(1);
        end
        res_carry_q <= res_carry_q | bus.C;
      end

      unique case (state_q)
        StIdle: begin
          en_q <= 1'b0;
          rw_q <= 1'b0;
          a_q  <= 1'b0;
          b_q  <= 1'b0;
          if (bus.in_valid) begin
            a_lat_q     <= clamp(bus.a_val);
            b_lat_q     <= clamp(bus.b_val);
            res_sum_q   <= '0;
            res_carry_q <= 1'b0;
            k_q         <= '0;
            state_q     <= StSend;
          end
        end
        StSend: begin
          en_q <= 1'b1;
          rw_q <= 1'b0;
          a_q  <= (int'(k_q) < int'(a_lat_q));
          b_q  <= (int'(k_q) < int'(b_lat_q));
          if (k_q == KW'(FRAME_LEN - 1)) begin
            k_q     <= '0;
            d_q     <= '0;
            state_q <= StDrain;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        StDrain: begin
          en_q <= 1'b1;
          rw_q <= 1'b1;
          a_q  <= 1'b0;
          b_q  <= 1'b0;
          if (d_q == DW'(DRAIN_LEN - 1)) begin
            state_q <= StDone;
          end else begin
            d_q <= d_q + DW'(1);
          end
        end
        StDone: begin
          en_q        <= 1'b0;
          rw_q        <= 1'b0;
          a_q         <= 1'b0;
          b_q         <= 1'b0;
          res_valid_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready      = (state_q == StIdle);
  assign bus.A             = a_q;
  assign bus.B             = b_q;
  assign bus.en            = en_q;
  assign bus.read_or_write = rw_q;
  assign bus.res_valid     = res_valid_q;
  assign bus.res_sum       = res_sum_q;
  assign bus.res_carry     = res_carry_q;

endmodule

// File: tb/tb_unary_adder_driver.sv
// Directed bench for unary_adder_driver with a behavioural unary adder that counts
// A/B ones during the read phase and replays them as dout ones during the write phase.
module tb_unary_adder_driver;

  logic clk;
  logic rst_n;
  logic force_dout;
  int   tot;

  int n_checks;
  int n_fail;

  logic [4:0] obs_a;
  logic [4:0] obs_b;
  logic [3:0] obs_sum;
  logic       obs_carry;
  logic       en_ok;
  logic       rw_ok;
  int         lat;
  int         pulses;

  unary_adder_driver_if #(.VAL_W(3), .RES_W(4)) bus ();

  unary_adder_driver #(
    .FRAME_LEN(5),
    .VAL_W    (3),
    .RES_W    (4),
    .DRAIN_LEN(12)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Adder model: reacts only to DUT outputs, which are stable at the falling edge.
  always @(negedge clk) begin
    if (!bus.en) tot <= 0;
    else if (!bus.read_or_write) tot <= tot + int'(bus.A) + int'(bus.B);
    else if (tot > 0) tot <= tot - 1;
    bus.dout <= force_dout | (bus.en & bus.read_or_write & (tot > 0));
  end

  // Accept one operand pair and observe the full transaction, j = edges since accept.
  task automatic run_txn(input logic [2:0] a, input logic [2:0] b, input int c_at);
    obs_a = '0; obs_b = '0; en_ok = 1'b1; rw_ok = 1'b1; lat = -1; pulses = 0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a_val = a; bus.b_val = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int j = 1; j <= 22; j++) begin
      @(negedge clk);
      bus.C = (j == c_at);
      if (j <= 5) begin
        obs_a[5-j] = bus.A;
        obs_b[5-j] = bus.B;
      end
      if (j <= 17 && (bus.en !== 1'b1 || bus.in_ready !== 1'b0)) en_ok = 1'b0;
      if (j <= 17 && bus.read_or_write !== (j >= 6)) rw_ok = 1'b0;
      if (j == 18 && (bus.en !== 1'b0 || bus.read_or_write !== 1'b0)) en_ok = 1'b0;
      if (bus.res_valid === 1'b1) begin
        pulses++;
        if (lat < 0) begin
          lat       = j;
          obs_sum   = bus.res_sum;
          obs_carry = bus.res_carry;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.in_valid = 1'b1; bus.a_val = 3'd3; bus.b_val = 3'd3;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.A, bus.B, bus.en, bus.read_or_write} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_streams got %b want 0000",
                         {bus.A, bus.B, bus.en, bus.read_or_write});
    end
    n_checks++;
    if ({bus.res_valid, bus.res_sum, bus.res_carry} !== 6'b0) begin
      n_fail++; $display("FAIL reset_result got %b want 000000",
                         {bus.res_valid, bus.res_sum, bus.res_carry});
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready got %b want 1", bus.in_ready);
    end
    rst_n = 1'b1; bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sum_4_4();
    run_txn(3'd4, 3'd4, 0);
    n_checks++;
    if (obs_a !== 5'b11110 || obs_b !== 5'b11110) begin
      n_fail++; $display("FAIL stream_4_4 got A=%b B=%b want 11110", obs_a, obs_b);
    end
    n_checks++;
    if (obs_sum !== 4'd8 || obs_carry !== 1'b0) begin
      n_fail++; $display("FAIL sum_4_4 got %0d c=%b want 8 c=0", obs_sum, obs_carry);
    end
    n_checks++;
    if (lat != 18 || pulses != 1) begin
      n_fail++; $display("FAIL latency_4_4 got lat=%0d pulses=%0d want 18/1", lat, pulses);
    end
    n_checks++;
    if (en_ok !== 1'b1 || rw_ok !== 1'b1) begin
      n_fail++; $display("FAIL phases_4_4 got en_ok=%b rw_ok=%b want 1/1", en_ok, rw_ok);
    end
    n_checks++;
    if (bus.res_sum !== 4'd8) begin
      n_fail++; $display("FAIL hold_4_4 got %0d want 8", bus.res_sum);
    end
  endtask

  task automatic test_zero();
    run_txn(3'd0, 3'd0, 0);
    n_checks++;
    if (obs_a !== 5'b00000 || obs_b !== 5'b00000 || en_ok !== 1'b1) begin
      n_fail++; $display("FAIL stream_0_0 got A=%b B=%b en_ok=%b want 0/0/1",
                         obs_a, obs_b, en_ok);
    end
    n_checks++;
    if (obs_sum !== 4'd0 || pulses != 1) begin
      n_fail++; $display("FAIL sum_0_0 got %0d pulses=%0d want 0/1", obs_sum, pulses);
    end
  endtask

  task automatic test_clamp();
    run_txn(3'd7, 3'd5, 0);
    n_checks++;
    if (obs_a !== 5'b11111 || obs_b !== 5'b11111) begin
      n_fail++; $display("FAIL stream_clamp got A=%b B=%b want 11111", obs_a, obs_b);
    end
    n_checks++;
    if (obs_sum !== 4'd10) begin
      n_fail++; $display("FAIL sum_clamp got %0d want 10", obs_sum);
    end
  endtask

  task automatic test_back_to_back();
    logic busy_ok;
    busy_ok = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a_val = 3'd2; bus.b_val = 3'd1;
    for (int j = 0; j <= 18; j++) begin
      @(negedge clk);
      if (j == 3) begin bus.a_val = 3'd3; bus.b_val = 3'd3; end
      if (j >= 1 && j <= 17 && bus.in_ready !== 1'b0) busy_ok = 1'b0;
    end
    n_checks++;
    if (busy_ok !== 1'b1) begin
      n_fail++; $display("FAIL b2b_busy got busy_ok=%b want 1", busy_ok);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.res_valid !== 1'b1 || bus.res_sum !== 4'd3) begin
      n_fail++; $display("FAIL b2b_first got rdy=%b vld=%b sum=%0d want 1/1/3",
                         bus.in_ready, bus.res_valid, bus.res_sum);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second_accept got rdy=%b want 0", bus.in_ready);
    end
    lat = -1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (bus.res_valid === 1'b1 && lat < 0) begin
        lat = j; obs_sum = bus.res_sum;
      end
    end
    n_checks++;
    if (lat != 18 || obs_sum !== 4'd6) begin
      n_fail++; $display("FAIL b2b_second got lat=%0d sum=%0d want 18/6", lat, obs_sum);
    end
  endtask

  task automatic test_reset_mid();
    logic quiet;
    quiet = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a_val = 3'd5; bus.b_val = 3'd5;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0; bus.in_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.A, bus.B, bus.en} !== 3'b000 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset got ABen=%b rdy=%b want 000/1",
                         {bus.A, bus.B, bus.en}, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1; bus.in_valid = 1'b0;
    for (int j = 0; j < 25; j++) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b0 || bus.en !== 1'b0) quiet = 1'b0;
    end
    n_checks++;
    if (quiet !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset_quiet got quiet=%b want 1", quiet);
    end
    run_txn(3'd1, 3'd2, 0);
    n_checks++;
    if (obs_a !== 5'b10000 || obs_b !== 5'b11000 || obs_sum !== 4'd3) begin
      n_fail++; $display("FAIL after_reset got A=%b B=%b sum=%0d want 10000/11000/3",
                         obs_a, obs_b, obs_sum);
    end
  endtask

  task automatic test_force_drain();
    force_dout = 1'b1;
    run_txn(3'd0, 3'd0, 10);
    force_dout = 1'b0;
    n_checks++;
    if (obs_sum !== 4'd12 || obs_carry !== 1'b1) begin
      n_fail++; $display("FAIL force_drain got sum=%0d c=%b want 12/1", obs_sum, obs_carry);
    end
    n_checks++;
    if (bus.res_carry !== 1'b1) begin
      n_fail++; $display("FAIL carry_hold got %b want 1", bus.res_carry);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    force_dout = 1'b0;
    bus.C = 1'b0; bus.in_valid = 1'b0; bus.a_val = '0; bus.b_val = '0;
    rst_n = 1'b0;
    test_reset();
    test_sum_4_4();
    test_zero();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
    test_force_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
